// File: rtl/div_seq_ctrl_pkg.sv
// Shared encodings for the divider sequencer, datapath and display decoder.
// State values double as the prStateLed encoding.
package div_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SHIFT = 3'd3,
    TRIAL = 3'd4,
    SHOWQ = 3'd5,
    SHOWR = 3'd6,
    ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ALU_PASS   = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_SHOW_Q = 2'b10;
  localparam logic [1:0] ALU_SHOW_R = 2'b11;

endpackage

// File: rtl/div_seq_ctrl_edge_detect.sv
// Rising-edge detector with a synchronous reset value for the history flop.
// Resetting the history to 1 suppresses an edge from a level held through reset.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the restoring shift/subtract divider: load, WIDTH shift/trial
// steps, then step the display through quotient and remainder on dv presses.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dv,
  input  logic          bZero,
  input  logic          remNeg,
  output logic          selA,
  output logic          wrA,
  output logic          wrB,
  output logic          clrR,
  output logic          shiftRQ,
  output logic          wrR,
  output logic          qBit,
  output logic [1:0]    aluOp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    prStateLed,
  output logic [CW-1:0] stepCount
);

  // Handshake: none beyond the dv button; a single rising edge advances
  // IDLE/SHOWQ/SHOWR/ERROR and edges seen in busy states are simply dropped.

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dv_rise;

  edge_detect #(.RST_VAL(1'b1)) u_dv_edge (
    .clk  (clock),
    .rst  (reset),
    .d    (dv),
    .rise (dv_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    selA    = 1'b0;
    wrA     = 1'b0;
    wrB     = 1'b0;
    clrR    = 1'b0;
    shiftRQ = 1'b0;
    wrR     = 1'b0;
    qBit    = 1'b0;
    aluOp   = ALU_PASS;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv_rise) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        selA    = 1'b1;
        wrA     = 1'b1;
        wrB     = 1'b1;
        clrR    = 1'b1;
        cnt_d   = CW'(WIDTH - 1);
        state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = bZero ? ERROR : SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        shiftRQ = 1'b1;
        state_d = TRIAL;
      end
      TRIAL: begin
        busy  = 1'b1;
        aluOp = ALU_SUB;
        // Restoring step: keep R - B only when it did not go negative.
        wrR   = ~remNeg;
        qBit  = ~remNeg;
        if (cnt_q == '0) begin
          state_d = SHOWQ;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = SHIFT;
        end
      end
      SHOWQ: begin
        done  = 1'b1;
        aluOp = ALU_SHOW_Q;
        if (dv_rise) state_d = SHOWR;
      end
      SHOWR: begin
        done  = 1'b1;
        aluOp = ALU_SHOW_R;
        if (dv_rise) state_d = IDLE;
      end
      ERROR: begin
        err = 1'b1;
        if (dv_rise) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prStateLed = state_q;
  assign stepCount  = cnt_q;

endmodule
